compressor_3to2: RTL and testbench

Bit-parallel 3:2 compressor (carry-save full-adder array) that reduces three WIDTH-bit operands to a sum vector and a carry vector. It is a building block for multiplier partial-product reduction trees: each bit position is an independent full adder, and the outputs are optionally registered. The output register has a valid flag so that trees can be pipelined.

---
 rtl/compressor_3to2_pkg.sv | 10 +
 rtl/compressor_3to2_cell.sv | 70 +++++++
 rtl/compressor_3to2.sv | 74 +++++++
 tb/tb_compressor_3to2.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/compressor_3to2_pkg.sv
// Shared constants for the 3:2 compressor slice.
package compressor_3to2_pkg;

    // Default number of independent bit columns in one compressor row.
    localparam int CMP_DEFAULT_WIDTH = 1;

    // Default output staging: 1 registers the result, 0 leaves it combinational.
    localparam bit CMP_DEFAULT_OUT_REG = 1'b1;

endpackage : compressor_3to2_pkg

// File: rtl/compressor_3to2_cell.sv
// One-bit full adder built from an XOR/XNOR cell and a 2:1 mux cell.
// The mux form of the carry keeps the carry path to one gate plus one mux.

// Two-input XOR with a selectable output inversion (XNOR when inv=1).
module compressor_3to2_xor (
    input  logic a,
    input  logic b,
    input  logic inv,
    output logic y
);

    // Exclusive-or, optionally inverted.
    always_comb begin
        y = (a ^ b) ^ inv;
    end

endmodule : compressor_3to2_xor

// Two-input multiplexer: y = sel ? d1 : d0.
module compressor_3to2_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    // Select between the two data inputs.
    always_comb begin
        y = sel ? d1 : d0;
    end

endmodule : compressor_3to2_mux2

module compressor_3to2_cell (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    output logic s,
    output logic c
);

    // p is the half-sum of a0/a1; it also steers the carry mux.
    logic p;

    // p = a0 ^ a1
    compressor_3to2_xor u_xor_p (
        .a   (a0),
        .b   (a1),
        .inv (1'b0),
        .y   (p)
    );

    // s = p ^ a2
    compressor_3to2_xor u_xor_s (
        .a   (p),
        .b   (a2),
        .inv (1'b0),
        .y   (s)
    );

    // When a0 and a1 differ the majority is decided by a2; when they
    // agree the majority is that common value, so a0 stands in for both.
    compressor_3to2_mux2 u_mux_c (
        .d0  (a0),
        .d1  (a2),
        .sel (p),
        .y   (c)
    );

endmodule : compressor_3to2_cell

// File: rtl/compressor_3to2.sv
// Bit-parallel 3:2 compressor (carry-save adder row). Each column is an
// independent full adder; cout[i] carries weight 2^(i+1) and is left
// unshifted for the consumer to align. Output stage optionally registered.
module compressor_3to2
    import compressor_3to2_pkg::*;
#(
    parameter int WIDTH   = CMP_DEFAULT_WIDTH,
    parameter bit OUT_REG = CMP_DEFAULT_OUT_REG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    output logic             out_valid,
    output logic [WIDTH-1:0] sout,
    output logic [WIDTH-1:0] cout
);

    // Raw per-column results straight out of the full-adder array.
    logic [WIDTH-1:0] col_sum;
    logic [WIDTH-1:0] col_carry;

    // One full adder per column; no carry crosses between columns.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
        compressor_3to2_cell u_cell (
            .a0 (a0[gi]),
            .a1 (a1[gi]),
            .a2 (a2[gi]),
            .s  (col_sum[gi]),
            .c  (col_carry[gi])
        );
    end

    if (OUT_REG) begin : g_reg
        logic             valid_d;
        logic             valid_q;
        logic [WIDTH-1:0] sout_d;
        logic [WIDTH-1:0] sout_q;
        logic [WIDTH-1:0] cout_d;
        logic [WIDTH-1:0] cout_q;

        // Next state: data loads every cycle, downstream qualifies with valid.
        always_comb begin
            valid_d = in_valid;
            sout_d  = col_sum;
            cout_d  = col_carry;
        end

        // Output register; reset clears it immediately and discards in-flight work.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                sout_q  <= '0;
                cout_q  <= '0;
            end else begin
                valid_q <= valid_d;
                sout_q  <= sout_d;
                cout_q  <= cout_d;
            end
        end

        assign out_valid = valid_q;
        assign sout      = sout_q;
        assign cout      = cout_q;
    end else begin : g_comb
        // Purely combinational pass-through; clk and rst are not used.
        assign out_valid = in_valid;
        assign sout      = col_sum;
        assign cout      = col_carry;
    end

endmodule : compressor_3to2

// File: tb/tb_compressor_3to2.sv
// Self-checking bench for compressor_3to2: directed literal checks plus a
// randomized stream compared every cycle against a column-count model.
module tb_compressor_3to2;

    logic clk = 1'b0;
    logic rst;

    // Registered, WIDTH=16
    logic        r_iv;
    logic [15:0] r_a0, r_a1, r_a2;
    logic        r_ov;
    logic [15:0] r_s, r_c;

    // Combinational, WIDTH=1
    logic        c1_iv;
    logic [0:0]  c1_a0, c1_a1, c1_a2;
    logic        c1_ov;
    logic [0:0]  c1_s, c1_c;

    // Combinational, WIDTH=8
    logic        c8_iv;
    logic [7:0]  c8_a0, c8_a1, c8_a2;
    logic        c8_ov;
    logic [7:0]  c8_s, c8_c;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    compressor_3to2 #(.WIDTH(16), .OUT_REG(1'b1)) u_r16 (
        .clk(clk), .rst(rst), .in_valid(r_iv),
        .a0(r_a0), .a1(r_a1), .a2(r_a2),
        .out_valid(r_ov), .sout(r_s), .cout(r_c)
    );

    compressor_3to2 #(.WIDTH(1), .OUT_REG(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(c1_iv),
        .a0(c1_a0), .a1(c1_a1), .a2(c1_a2),
        .out_valid(c1_ov), .sout(c1_s), .cout(c1_c)
    );

    compressor_3to2 #(.WIDTH(8), .OUT_REG(1'b0)) u_c8 (
        .clk(clk), .rst(rst), .in_valid(c8_iv),
        .a0(c8_a0), .a1(c8_a1), .a2(c8_a2),
        .out_valid(c8_ov), .sout(c8_s), .cout(c8_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural column model: count the ones in each column; the low bit of
    // the count is the sum, the high bit is the carry.
    task automatic col_model(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                             output logic [15:0] s, output logic [15:0] c);
        int cnt;
        s = '0;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            cnt  = int'(x[i]) + int'(y[i]) + int'(z[i]);
            s[i] = (cnt % 2) == 1;
            c[i] = (cnt / 2) == 1;
        end
    endtask

    // Operands the registered DUT should be presenting results for this cycle.
    logic        m_v;
    logic [15:0] m_a0, m_a1, m_a2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v  <= 1'b0;
            m_a0 <= '0;
            m_a1 <= '0;
            m_a2 <= '0;
        end else begin
            m_v  <= r_iv;
            m_a0 <= r_a0;
            m_a1 <= r_a1;
            m_a2 <= r_a2;
        end
    end

    // Every-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        logic [15:0] es, ec, e8s, e8c;
        if (chk_en) begin
            if (rst) begin
                chk("rst_hold_ov", {31'b0, r_ov}, 32'd0);
                chk("rst_hold_sout", {16'b0, r_s}, 32'd0);
                chk("rst_hold_cout", {16'b0, r_c}, 32'd0);
            end else begin
                col_model(m_a0, m_a1, m_a2, es, ec);
                chk("r16_ov", {31'b0, r_ov}, {31'b0, m_v});
                chk("r16_sout", {16'b0, r_s}, {16'b0, es});
                chk("r16_cout", {16'b0, r_c}, {16'b0, ec});
                if (r_ov)
                    chk("r16_invariant", {15'b0, r_s} + {15'b0, r_c, 1'b0},
                        32'(m_a0) + 32'(m_a1) + 32'(m_a2));
            end
            col_model({8'b0, c8_a0}, {8'b0, c8_a1}, {8'b0, c8_a2}, e8s, e8c);
            chk("c8_sout", {24'b0, c8_s}, {24'b0, e8s[7:0]});
            chk("c8_cout", {24'b0, c8_c}, {24'b0, e8c[7:0]});
            chk("c8_ov", {31'b0, c8_ov}, {31'b0, c8_iv});
        end
    end

    initial begin
        logic [7:0] s_tab;
        logic [7:0] c_tab;
        logic [2:0] v;
        s_tab = 8'b1001_0110;
        c_tab = 8'b1110_1000;

        rst = 1'b1;
        r_iv = 1'b0; r_a0 = '0; r_a1 = '0; r_a2 = '0;
        c1_iv = 1'b0; c1_a0 = '0; c1_a1 = '0; c1_a2 = '0;
        c8_iv = 1'b0; c8_a0 = '0; c8_a1 = '0; c8_a2 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("reset_ov", {31'b0, r_ov}, 32'd0);
        chk("reset_sout", {16'b0, r_s}, 32'd0);
        chk("reset_cout", {16'b0, r_c}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;

        // Exhaustive single column, combinational
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            c1_a0 = v[0]; c1_a1 = v[1]; c1_a2 = v[2];
            c1_iv = v[0];
            #1;
            $display("col {a2,a1,a0}=%b -> s=%b c=%b", v, c1_s, c1_c);
            chk("col_sout", {31'b0, c1_s}, {31'b0, s_tab[k]});
            chk("col_cout", {31'b0, c1_c}, {31'b0, c_tab[k]});
            chk("col_ov", {31'b0, c1_ov}, {31'b0, v[0]});
        end

        // Wide vector, combinational
        c8_iv = 1'b1; c8_a0 = 8'hFF; c8_a1 = 8'h0F; c8_a2 = 8'hF0;
        #1;
        $display("wide a0=FF a1=0F a2=F0 -> s=%h c=%h", c8_s, c8_c);
        chk("wide_sout", {24'b0, c8_s}, 32'h00);
        chk("wide_cout", {24'b0, c8_c}, 32'hFF);
        chk("wide_sum", {24'b0, c8_s} + {23'b0, c8_c, 1'b0}, 32'd510);

        // Registered latency
        @(posedge clk); #2;
        r_iv = 1'b1; r_a0 = 16'h0001; r_a1 = 16'h0001; r_a2 = 16'h0000;
        @(posedge clk); #2;
        r_iv = 1'b0; r_a0 = '0; r_a1 = '0;
        #1;
        $display("latency: ov=%b s=%h c=%h", r_ov, r_s, r_c);
        chk("lat_ov", {31'b0, r_ov}, 32'd1);
        chk("lat_sout", {16'b0, r_s}, 32'h0);
        chk("lat_cout", {16'b0, r_c}, 32'h1);
        @(posedge clk); #3;
        chk("lat_ov_drop", {31'b0, r_ov}, 32'd0);

        // Random stream
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #2;
            r_iv = 1'($urandom_range(0, 1));
            r_a0 = 16'($urandom); r_a1 = 16'($urandom); r_a2 = 16'($urandom);
            c8_iv = 1'($urandom_range(0, 1));
            c8_a0 = 8'($urandom); c8_a1 = 8'($urandom); c8_a2 = 8'($urandom);
        end
        $display("random stream: %0d vectors so far, %0d errors", n_vec, n_err);

        // Back-to-back operands, one result per cycle
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #2;
            r_iv = (k < 8);
            r_a0 = 16'(16'h1111 * k); r_a1 = 16'(16'h0F0F + k); r_a2 = 16'(16'h8001 ^ k);
            #1;
            if (k > 0) begin
                $display("b2b result %0d: ov=%b s=%h c=%h", k - 1, r_ov, r_s, r_c);
                chk("b2b_ov", {31'b0, r_ov}, 32'd1);
            end
        end
        @(posedge clk); #3;
        chk("b2b_end_ov", {31'b0, r_ov}, 32'd0);

        // Async reset mid-stream
        @(posedge clk); #2;
        r_iv = 1'b1; r_a0 = 16'hFFFF; r_a1 = 16'h0000; r_a2 = 16'h0000;
        @(posedge clk); #2;
        #1;
        chk("pre_rst_sout", {16'b0, r_s}, 32'hFFFF);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        $display("async reset: ov=%b s=%h c=%h", r_ov, r_s, r_c);
        chk("arst_ov", {31'b0, r_ov}, 32'd0);
        chk("arst_sout", {16'b0, r_s}, 32'd0);
        chk("arst_cout", {16'b0, r_c}, 32'd0);
        @(posedge clk); #2;
        r_iv = 1'b0;
        rst = 1'b0;
        @(posedge clk); #3;
        chk("post_rst_idle_ov", {31'b0, r_ov}, 32'd0);
        #(-1 + 1);
        r_iv = 1'b1; r_a0 = 16'h00F0; r_a1 = 16'h0FF0; r_a2 = 16'h0F00;
        @(posedge clk); #2;
        r_iv = 1'b0;
        #1;
        $display("post reset first: ov=%b s=%h c=%h", r_ov, r_s, r_c);
        chk("post_rst_ov", {31'b0, r_ov}, 32'd1);
        chk("post_rst_sout", {16'b0, r_s}, 32'h0000);
        chk("post_rst_cout", {16'b0, r_c}, 32'h0FF0);
        @(posedge clk); #3;

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_compressor_3to2
